// File: rtl/spi_sram_master.sv
// SPI mode-0 initiator turning single-byte requests into 23LC-style READ/WRITE SRAM frames.
// Latency: rsp_valid 2*(16+ADDR_W) clks after accept; 16 clks for a sequential burst continuation.
// Backpressure: req_ready only in IDLE (or HOLD for a matching next-address request).
// Optional sequential burst continuation: define SPI_SRAM_MASTER_BURST_EN.
module spi_sram_master #(
    parameter int         ADDR_W    = 24,
    parameter logic [7:0] CMD_READ  = 8'h03,
    parameter logic [7:0] CMD_WRITE = 8'h02,
    parameter int         CS_IDLE   = 2,
    parameter int         HOLD_MAX  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_wdata,
    output logic              rsp_valid,
    output logic [7:0]        rsp_rdata,
    output logic              cs_n,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso
);
    localparam int         TOT       = 16 + ADDR_W;
    localparam logic [5:0] GAP_LOAD  = 6'(CS_IDLE - 1);
    localparam logic [5:0] ADDR_LOAD = 6'(ADDR_W - 1);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CMD  = 3'd1;
    localparam logic [2:0] ST_ADDR = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_GAP  = 3'd4;
`ifdef SPI_SRAM_MASTER_BURST_EN
    localparam logic [2:0] ST_HOLD   = 3'd5;
    localparam logic [5:0] HOLD_LAST = 6'(HOLD_MAX - 1);
`endif

    logic [2:0]     state;
    logic [5:0]     bit_cnt;    // bits left in the current field, or gap/hold clock count
    logic [TOT-1:0] shreg;      // outgoing frame, MSB is the bit on the wire
    logic [6:0]     rx_sh;      // first seven received data bits
    logic           armed;      // low until the first clock after reset release
    logic           cur_wr;
    logic [7:0]     cmd_byte;
    logic           accept;

    assign cmd_byte = req_wr ? CMD_WRITE : CMD_READ;
    // Driving mosi straight from the frame register keeps it glitch-free and only
    // lets it move when the frame shifts (falling sclk edges) or is loaded.
    assign mosi     = shreg[TOT-1];
    assign accept   = req_valid && req_ready;

`ifdef SPI_SRAM_MASTER_BURST_EN
    logic [ADDR_W-1:0] last_addr;
    logic [ADDR_W-1:0] next_addr;
    assign next_addr = last_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign req_ready = armed && ((state == ST_IDLE) ||
                       ((state == ST_HOLD) && req_valid && (req_wr == cur_wr) && (req_addr == next_addr)));
`else
    logic unused_hold;
    assign unused_hold = (HOLD_MAX > 0);
    assign req_ready   = armed && (state == ST_IDLE);
`endif

    // Frame sequencer: two clks per bit, frames cs_n, samples miso in DATA, paces the cs_n gap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            bit_cnt   <= 6'd0;
            shreg     <= '0;
            rx_sh     <= 7'd0;
            armed     <= 1'b0;
            cur_wr    <= 1'b0;
            cs_n      <= 1'b1;
            sclk      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
`ifdef SPI_SRAM_MASTER_BURST_EN
            last_addr <= '0;
`endif
        end else begin
            armed     <= 1'b1;
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state   <= ST_CMD;
                        bit_cnt <= 6'd7;
                        cs_n    <= 1'b0;
                        sclk    <= 1'b0;
                        shreg   <= {cmd_byte, req_addr, (req_wr ? req_wdata : 8'h00)};
                        cur_wr  <= req_wr;
`ifdef SPI_SRAM_MASTER_BURST_EN
                        last_addr <= req_addr;
`endif
                    end
                end
                ST_CMD, ST_ADDR, ST_DATA: begin
                    if (!sclk) begin
                        sclk <= 1'b1;
                    end else begin
                        sclk  <= 1'b0;
                        shreg <= {shreg[TOT-2:0], 1'b0};
                        if (state == ST_DATA)
                            rx_sh <= {rx_sh[5:0], miso};
                        if (bit_cnt != 6'd0) begin
                            bit_cnt <= bit_cnt - 6'd1;
                        end else if (state == ST_CMD) begin
                            state   <= ST_ADDR;
                            bit_cnt <= ADDR_LOAD;
                        end else if (state == ST_ADDR) begin
                            state   <= ST_DATA;
                            bit_cnt <= 6'd7;
                        end else begin
                            rsp_valid <= 1'b1;
                            if (!cur_wr)
                                rsp_rdata <= {rx_sh, miso};
`ifdef SPI_SRAM_MASTER_BURST_EN
                            state   <= ST_HOLD;
                            bit_cnt <= 6'd0;
`else
                            state   <= ST_GAP;
                            bit_cnt <= GAP_LOAD;
                            cs_n    <= 1'b1;
`endif
                        end
                    end
                end
                ST_GAP: begin
                    if (bit_cnt == 6'd0)
                        state <= ST_IDLE;
                    else
                        bit_cnt <= bit_cnt - 6'd1;
                end
`ifdef SPI_SRAM_MASTER_BURST_EN
                ST_HOLD: begin
                    if (accept) begin
                        // Sequential continuation: the SRAM auto-increments, so only the data byte goes out.
                        state     <= ST_DATA;
                        bit_cnt   <= 6'd7;
                        shreg     <= {(req_wr ? req_wdata : 8'h00), {(TOT-8){1'b0}}};
                        last_addr <= req_addr;
                    end else if (req_valid || (bit_cnt == HOLD_LAST)) begin
                        cs_n    <= 1'b1;
                        state   <= ST_GAP;
                        bit_cnt <= GAP_LOAD;
                    end else begin
                        bit_cnt <= bit_cnt + 6'd1;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_sram_master.sv
module tb_spi_sram_master;
    localparam int CS_IDLE = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wr = 1'b0;
    logic [23:0] req_addr = 24'h0;
    logic [7:0]  req_wdata = 8'h00;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        cs_n, sclk, mosi;
    logic        miso = 1'b0;

    spi_sram_master #(.ADDR_W(24), .CMD_READ(8'h03), .CMD_WRITE(8'h02),
                      .CS_IDLE(CS_IDLE), .HOLD_MAX(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .cs_n(cs_n), .sclk(sclk), .mosi(mosi), .miso(miso));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    // reference memory (model) and the serial SRAM's own storage
    logic [7:0] mmem [logic [23:0]];
    logic [7:0] smem [logic [23:0]];
    logic [7:0] model_last = 8'h00;

    function automatic logic [7:0] model_rd(input logic [23:0] a);
        return mmem.exists(a) ? mmem[a] : 8'h00;
    endfunction

    function automatic logic [7:0] sram_rd(input logic [23:0] a);
        return smem.exists(a) ? smem[a] : 8'h00;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Serial SRAM + wire monitor, sampled mid-cycle.
    logic        prev_cs = 1'b1, prev_sclk = 1'b0;
    logic [63:0] fb = 64'd0;
    int          fn = 0;
    logic [63:0] fr_bits[$];
    int          fr_n[$];
    int          s_cnt = 0;
    logic [7:0]  s_cmd = 8'h00, s_dat = 8'h00, s_byte;
    logic [23:0] s_addr = 24'h0;
    int          hi_run = 0;
    int          gap_viol = 0;

    always @(negedge clk) begin
        if (cs_n) begin
            if (!prev_cs) begin
                fr_bits.push_back(fb);
                fr_n.push_back(fn);
            end
            s_cnt = 0; fb = 64'd0; fn = 0;
            hi_run++;
        end else begin
            if (prev_cs && hi_run < CS_IDLE) gap_viol++;
            hi_run = 0;
            if (sclk && !prev_sclk) begin
                fb = {fb[62:0], mosi};
                fn++;
                if (s_cnt < 8) s_cmd = {s_cmd[6:0], mosi};
                else if (s_cnt < 32) s_addr = {s_addr[22:0], mosi};
                else begin
                    s_dat = {s_dat[6:0], mosi};
                    if ((s_cnt - 32) % 8 == 7) begin
                        if (s_cmd == 8'h02) smem[s_addr] = s_dat;
                        s_addr = s_addr + 24'd1;
                    end
                end
                s_cnt++;
            end
            if (!sclk && prev_sclk && s_cnt >= 32 && s_cmd == 8'h03) begin
                s_byte = sram_rd(s_addr);
                miso = s_byte[3'(7 - ((s_cnt - 32) % 8))];
            end
        end
        prev_cs = cs_n;
        prev_sclk = sclk;
    end

    // Present a request and wait (bounded) for acceptance; acc = index of the accept edge.
    task automatic issue(input logic wr, input logic [23:0] a, input logic [7:0] d,
                         input logic keep, output int acc);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = d;
        #1;
        n = 0;
        while (!req_ready && n < 400) begin
            @(negedge clk); #1; n++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 64'd0, 64'd1);
            req_valid = 1'b0;
            acc = -1;
            return;
        end
        @(posedge clk); #1;
        acc = cyc;
        if (!keep) begin
            req_valid = 1'b0;
            req_addr = 24'($urandom);
            req_wdata = 8'($urandom);
        end
    endtask

    task automatic do_txn(input logic wr, input logic [23:0] a, input logic [7:0] d,
                          input logic keep, input int exp_lat, input logic [7:0] exp_rd);
        int acc, n;
        issue(wr, a, d, keep, acc);
        if (acc < 0) return;
        if (wr) mmem[a] = d;
        model_last = exp_rd;
        n = 0;
        while (!rsp_valid && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk("rsp_latency", 64'(cyc - acc), 64'(exp_lat));
        chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rd));
        @(posedge clk); #1;
        chk("rsp_one_pulse", 64'(rsp_valid), 64'd0);
    endtask

    task automatic chk_frame(input logic [63:0] exp_bits, input int exp_n);
        int n = 0;
        while (fr_n.size() == 0 && n < 100) begin
            @(negedge clk); #1; n++;
        end
        if (fr_n.size() == 0) begin
            chk("frame_timeout", 64'd0, 64'd1);
            return;
        end
        chk("frame_len", 64'(fr_n.pop_front()), 64'(exp_n));
        chk("frame_bits", fr_bits.pop_front(), exp_bits);
    endtask

    task automatic mid_reset(input int after);
        int pulses = 0;
        repeat (after) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_cs_n", 64'(cs_n), 64'd1);
        chk("rst_sclk", 64'(sclk), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_last = 8'h00;
        #1;
        chk("rel_req_ready_0", 64'(req_ready), 64'd0);
        @(negedge clk); #1;
        chk("rel_req_ready_1", 64'(req_ready), 64'd1);
        repeat (30) begin
            @(posedge clk); #1;
            if (rsp_valid) pulses++;
        end
        chk("abandoned_no_rsp", 64'(pulses), 64'd0);
        chk("rst_rdata", 64'(rsp_rdata), 64'd0);
        fr_bits.delete();
        fr_n.delete();
    endtask

    typedef struct {
        logic        wr;
        logic [23:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_rd;
    } vec_t;

    vec_t tbl [9];
    logic [23:0] pool [4];

    initial begin
        int acc;
        logic w;
        logic [23:0] a;
        logic [7:0] d, e;

        tbl[0] = '{1'b0, 24'h001234, 8'h00, 8'hA5};
        tbl[1] = '{1'b1, 24'h00FFFF, 8'h5A, 8'hA5};
        tbl[2] = '{1'b0, 24'h00FFFF, 8'h00, 8'h5A};
        tbl[3] = '{1'b0, 24'h000010, 8'h00, 8'h3C};
        tbl[4] = '{1'b1, 24'h800000, 8'h00, 8'h3C};
        tbl[5] = '{1'b0, 24'h800000, 8'h00, 8'h00};
        tbl[6] = '{1'b1, 24'hFFFFFF, 8'hFF, 8'h00};
        tbl[7] = '{1'b0, 24'hFFFFFF, 8'h00, 8'hFF};
        tbl[8] = '{1'b0, 24'h000000, 8'h00, 8'h44};
        pool[0] = 24'h000010; pool[1] = 24'h001234; pool[2] = 24'hABCDEF; pool[3] = 24'h00FFFF;

        smem[24'h001234] = 8'hA5; mmem[24'h001234] = 8'hA5;
        smem[24'h000010] = 8'h3C; mmem[24'h000010] = 8'h3C;
        smem[24'h000100] = 8'h11; mmem[24'h000100] = 8'h11;
        smem[24'h000101] = 8'h22; mmem[24'h000101] = 8'h22;
        smem[24'h000000] = 8'h44; mmem[24'h000000] = 8'h44;

        // reset state
        repeat (3) @(negedge clk);
        #1;
        chk("reset_cs_n", 64'(cs_n), 64'd1);
        chk("reset_sclk", 64'(sclk), 64'd0);
        chk("reset_mosi", 64'(mosi), 64'd0);
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_rdata", 64'(rsp_rdata), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("release_ready_0", 64'(req_ready), 64'd0);
        @(negedge clk); #1;
        chk("release_ready_1", 64'(req_ready), 64'd1);

        // directed table: reads, writes, address extremes, rdata hold on writes
        for (int i = 0; i < 9; i++) begin
            do_txn(tbl[i].wr, tbl[i].addr, tbl[i].wdata, 1'b0, 80, tbl[i].exp_rd);
            chk_frame(64'({(tbl[i].wr ? 8'h02 : 8'h03), tbl[i].addr,
                           (tbl[i].wr ? tbl[i].wdata : 8'h00)}), 40);
        end

        // req_valid held across three reads
        do_txn(1'b0, 24'h001234, 8'h00, 1'b1, 80, model_rd(24'h001234));
        do_txn(1'b0, 24'h000010, 8'h00, 1'b1, 80, model_rd(24'h000010));
        do_txn(1'b0, 24'h00FFFF, 8'h00, 1'b0, 80, model_rd(24'h00FFFF));
        chk_frame(64'({8'h03, 24'h001234, 8'h00}), 40);
        chk_frame(64'({8'h03, 24'h000010, 8'h00}), 40);
        chk_frame(64'({8'h03, 24'h00FFFF, 8'h00}), 40);
        chk("cs_gap_violations", 64'(gap_viol), 64'd0);

        // reset in the data phase of a read
        issue(1'b0, 24'h001234, 8'h00, 1'b0, acc);
        mid_reset(70);

        // reset in the address phase of a write: the write must not land
        issue(1'b1, 24'h000010, 8'h77, 1'b0, acc);
        mid_reset(30);
        do_txn(1'b0, 24'h000010, 8'h00, 1'b0, 80, 8'h3C);
        chk_frame(64'({8'h03, 24'h000010, 8'h00}), 40);

        // randomized traffic against the memory model
        for (int i = 0; i < 16; i++) begin
            w = 1'($urandom);
            a = ($urandom_range(0, 3) == 0) ? 24'($urandom) : pool[$urandom_range(0, 3)];
            d = 8'($urandom);
            e = w ? model_last : model_rd(a);
            do_txn(w, a, d, 1'b0, 80, e);
            chk_frame(64'({(w ? 8'h02 : 8'h03), a, (w ? d : 8'h00)}), 40);
        end

`ifdef SPI_SRAM_MASTER_BURST_EN
        do_txn(1'b0, 24'h000100, 8'h00, 1'b0, 80, model_rd(24'h000100));
        do_txn(1'b0, 24'h000101, 8'h00, 1'b0, 16, model_rd(24'h000101));
        chk_frame(64'({8'h03, 24'h000100, 16'h0000}), 48);
        do_txn(1'b0, 24'hFFFFFF, 8'h00, 1'b0, 80, model_rd(24'hFFFFFF));
        do_txn(1'b0, 24'h000000, 8'h00, 1'b0, 16, model_rd(24'h000000));
        chk_frame(64'({8'h03, 24'hFFFFFF, 16'h0000}), 48);
        do_txn(1'b0, 24'h000100, 8'h00, 1'b0, 80, model_rd(24'h000100));
        do_txn(1'b0, 24'h000101, 8'h00, 1'b0, 16, model_rd(24'h000101));
        do_txn(1'b0, 24'h000200, 8'h00, 1'b0, 80, model_rd(24'h000200));
        chk_frame(64'({8'h03, 24'h000100, 16'h0000}), 48);
        chk_frame(64'({8'h03, 24'h000200, 8'h00}), 40);
`endif

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
